// File: rtl/data_memory_responder.sv
// Data-memory responder: byte-addressed array with a fixed multi-cycle access
// latency; the CPU stalls on BUSYWAIT until a registered read or a write commits.
module data_memory_responder #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int LATENCY = 5
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              READ,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] ADDRESS,
  input  logic [DATA_W-1:0] WRITEDATA,
  output logic [DATA_W-1:0] READDATA,
  output logic              BUSYWAIT
);

  // state | meaning
  // IDLE  | waiting for READ/WRITE; request latched on the next edge
  // BUSY  | counting down the access latency; commit when cnt reaches 0
  // DONE  | one-cycle guard so a request still held does not re-trigger
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic              op_write;
  logic [ADDR_W-1:0] a_l;
  logic [DATA_W-1:0] d_l;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic              req;
  logic              commit;

  assign req    = READ | WRITE;
  assign commit = (state == BUSY) && (cnt == 4'd0);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = BUSY;
      BUSY:    if (cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    BUSYWAIT = ((state == IDLE) && req) || (state == BUSY);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt      <= 4'd0;
      op_write <= 1'b0;
      a_l      <= '0;
      d_l      <= '0;
      READDATA <= '0;
    end else if ((state == IDLE) && req) begin
      cnt      <= 4'(LATENCY - 1);
      op_write <= WRITE;  // WRITE wins when both are raised
      a_l      <= ADDRESS;
      d_l      <= WRITEDATA;
    end else if (state == BUSY) begin
      if (cnt != 4'd0)    cnt      <= cnt - 4'd1;
      else if (!op_write) READDATA <= mem[a_l];
    end
  end

  // Array is deliberately not reset; an aborted access never reaches commit.
  always_ff @(posedge CLK) begin
    if (commit && op_write) mem[a_l] <= d_l;
  end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Memory-side responder for the CPU's data-memory port, used by the `lwi`/`swi`/`lwd`/`swd` path.
- The CPU is the initiator: it raises READ or WRITE with ADDRESS and WRITEDATA, then stalls while BUSYWAIT is high.
- This block holds a byte-addressed array and models a multi-cycle access latency.
- It completes each transfer with a registered READDATA and a BUSYWAIT drop.

Parameters:
- ADDR_W, 8, address width; the array holds 2**ADDR_W bytes.
- DATA_W, 8, data word width; one word per address.
- LATENCY, 5, clock edges from request latch to commit; legal range 1..15.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- READ  input  1  read request from the CPU; held until BUSYWAIT falls.
- WRITE  input  1  write request from the CPU; held until BUSYWAIT falls.
- ADDRESS  input  ADDR_W  byte address of the access.
- WRITEDATA  input  DATA_W  store data; valid while WRITE is high.
- READDATA  output  DATA_W  load result; registered; valid from the edge where BUSYWAIT falls.
- BUSYWAIT  output  1  stall to the CPU.

Behaviour:
- States: IDLE, BUSY, DONE. There is a 4-bit down-counter CNT, plus latched registers OP (read/write), A_L (address) and D_L (data).
- Reset (asynchronous, any time):
  - state=IDLE, CNT=0, READDATA=0, BUSYWAIT=0.
  - Array contents are NOT cleared.
  - An access in flight is aborted: no array write, no READDATA update.
- BUSYWAIT (combinational) = (state==IDLE and (READ or WRITE)) or state==BUSY.
  - The CPU therefore sees the stall in the same cycle it raises a request.
- IDLE, rising edge with READ or WRITE high:
  - Latch ADDRESS into A_L and WRITEDATA into D_L.
  - Set OP=write if WRITE is high, else read. WRITE has priority when both are high.
  - Set CNT=LATENCY-1 and go to BUSY.
  - Request inputs are not sampled again until the next return to IDLE; changes during BUSY are ignored.
- BUSY, each rising edge:
  - If CNT!=0, decrement CNT.
  - If CNT==0, commit and go to DONE:
    - write: mem[A_L] <= D_L; READDATA unchanged.
    - read: READDATA <= mem[A_L].
- Timing: the latch edge is E, the commit edge is E+LATENCY, and BUSYWAIT is low immediately after E+LATENCY. LATENCY=1 commits on the edge after the latch.
- DONE:
  - BUSYWAIT=0 regardless of inputs. This one-cycle guard lets the CPU drop its request at the commit edge without re-triggering.
  - The next rising edge always goes to IDLE. A request still high then starts a new access one cycle later.
- READDATA holds its last read value until the next read commit or reset.
- ADDRESS wraps naturally at ADDR_W bits; there is no out-of-range case.
- Read-after-write to the same address returns the new data, because the write commits before any later latch.

Test Plan:
- Reset: RESET=1 at t=0, then released → READDATA=0, BUSYWAIT=0, state IDLE; a write followed by RESET mid-BUSY → the later read of that address returns the old value.
- Write then read, LATENCY=5: WRITE=1, ADDRESS=0x03, WRITEDATA=0x0A → BUSYWAIT high the same cycle and low after the 5th edge past the latch. Then READ=1, ADDRESS=0x03 → READDATA=0x0A at that read's commit edge.
- Latency count: for LATENCY=1 and LATENCY=5, count edges from the latch to the BUSYWAIT fall → exactly 1 and exactly 5 respectively.
- Request held through DONE: READ held high for 2 cycles after BUSYWAIT falls → BUSYWAIT low for exactly 1 cycle (DONE), then a second read starts; no glitch on READDATA.
- Both asserted: READ=WRITE=1, ADDRESS=0xFF, WRITEDATA=0x5A → treated as a write; a subsequent read of 0xFF returns 0x5A, and READDATA is unchanged during the write.
- Input change during BUSY: after the latch, ADDRESS changes to 0x10 and WRITEDATA to 0x77 → the commit uses the latched address and data; mem[0x10] is untouched.
